// File: rtl/cdc_pattern_checker_if.sv
// Capture source and miscompare-log bus of the CDC pattern checker.
// The master side is the source/reader; the slave side is the checker itself.
interface cdc_pattern_checker_if #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 16,
    parameter int LOG_DEPTH = 4
);
    localparam int LOG_CW = $clog2(LOG_DEPTH + 1);

    logic [DATA_W-1:0]         capture_data;
    logic                      capture_edge;
    logic                      log_rd_en;
    logic                      log_valid;
    logic [CNT_W+2*DATA_W-1:0] log_data;
    logic [LOG_CW-1:0]         log_count;
    logic                      log_overflow;

    modport master (
        output capture_data, capture_edge, log_rd_en,
        input  log_valid, log_data, log_count, log_overflow
    );

    modport slave (
        input  capture_data, capture_edge, log_rd_en,
        output log_valid, log_data, log_count, log_overflow
    );
endinterface

// File: rtl/cdc_pattern_checker.sv
// Receive-side CDC checker: synchronises a toggle strobe, samples the raw data bus on each
// toggle, compares it with a locally generated pattern, counts and logs miscompares.
module cdc_pattern_checker #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int LOG_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [1:0]            mode,
    cdc_pattern_checker_if.slave  bus,
    output logic [CNT_W-1:0]      num_edges,
    output logic [CNT_W-1:0]      num_miscompares,
    output logic [2*DATA_W-1:0]   first_miscompare,
    output logic                  pass
);
    localparam int LOG_AW  = $clog2(LOG_DEPTH);
    localparam int LOG_CW  = $clog2(LOG_DEPTH + 1);
    localparam int ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam int HALF    = DATA_W / 2;
    localparam int ENTRY_W = CNT_W + 2 * DATA_W;
    localparam logic [ARM_W-1:0]  ARM_INIT = ARM_W'(SYNC_STAGES + 1);
    localparam logic [LOG_CW-1:0] LOG_FULL = LOG_CW'(LOG_DEPTH);

    function automatic logic [DATA_W-1:0] pattern_start(input logic [1:0] m);
        logic [DATA_W-1:0] p;
        p = '0;
        case (m)
            2'b01:   p = '0;
            2'b10:   p[0] = 1'b1;
            default: begin
                p[0]        = 1'b1;
                p[DATA_W-1] = 1'b1;
            end
        endcase
        return p;
    endfunction

    // Mirrored pair: low half walks up, high half walks down; wrap once the low half tops out.
    function automatic logic [DATA_W-1:0] pattern_next(input logic [1:0] m,
                                                       input logic [DATA_W-1:0] p);
        logic [DATA_W-1:0] n;
        case (m)
            2'b01:   n = p + 1'b1;
            2'b10:   n = {p[DATA_W-2:0], p[DATA_W-1]};
            default: begin
                if (p[HALF-1])
                    n = pattern_start(2'b00);
                else
                    n = {p[DATA_W-1:HALF] >> 1, p[HALF-1:0] << 1};
            end
        endcase
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ---- stage p0: synchroniser, edge detect, arming window
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   edge_p0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
            arm_cnt   <= ARM_INIT;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.capture_edge};
            sync_prev <= sync_q[SYNC_STAGES-1];
            if (arm_cnt != '0)
                arm_cnt <= arm_cnt - 1'b1;
        end
    end

    assign edge_p0 = (sync_q[SYNC_STAGES-1] ^ sync_prev) && (arm_cnt == '0);

    // ---- stage p1: sample raw bus and expected pattern, advance the generator
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] pat_q;
    logic [DATA_W-1:0] act_p1;
    logic [DATA_W-1:0] exp_p1;
    logic              vld_p1;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            mode_q <= mode;
            pat_q  <= pattern_start(mode);
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= edge_p0;
            if (edge_p0)
                pat_q <= pattern_next(mode_q, pat_q);
        end
    end

    always_ff @(posedge clk) begin
        if (edge_p0) begin
            act_p1 <= bus.capture_data;
            exp_p1 <= pat_q;
        end
    end

    // ---- stage p2: counters, first-miscompare capture and log push
    logic             miscmp_p1;
    logic [CNT_W-1:0] edge_idx_p1;

    assign miscmp_p1   = vld_p1 && (act_p1 != exp_p1);
    assign edge_idx_p1 = sat_inc(num_edges);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            num_edges        <= '0;
            num_miscompares  <= '0;
            first_miscompare <= '0;
        end else if (vld_p1) begin
            num_edges <= edge_idx_p1;
            if (miscmp_p1) begin
                num_miscompares <= sat_inc(num_miscompares);
                if (num_miscompares == '0)
                    first_miscompare <= {exp_p1, act_p1};
            end
        end
    end

    assign pass = (num_edges != '0) && (num_miscompares == '0);

    logic [ENTRY_W-1:0] log_mem [LOG_DEPTH];
    logic [LOG_AW-1:0]  wr_ptr;
    logic [LOG_AW-1:0]  rd_ptr;
    logic [LOG_CW-1:0]  log_cnt;
    logic               log_ovf;
    logic               log_pop;
    logic               log_push;

    // A pop in the same cycle frees the slot, so a full log still accepts the push.
    assign log_pop  = bus.log_rd_en && (log_cnt != '0);
    assign log_push = miscmp_p1 && ((log_cnt != LOG_FULL) || log_pop);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            log_cnt <= '0;
            log_ovf <= 1'b0;
        end else begin
            if (log_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (log_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (log_push && !log_pop)
                log_cnt <= log_cnt + 1'b1;
            else if (!log_push && log_pop)
                log_cnt <= log_cnt - 1'b1;
            if (miscmp_p1 && !log_push)
                log_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (log_push)
            log_mem[wr_ptr] <= {edge_idx_p1, exp_p1, act_p1};
    end

    assign bus.log_valid    = (log_cnt != '0);
    assign bus.log_data     = (log_cnt != '0) ? log_mem[rd_ptr] : '0;
    assign bus.log_count    = log_cnt;
    assign bus.log_overflow = log_ovf;
endmodule

// File: tb/tb_cdc_pattern_checker.sv
// Bench for cdc_pattern_checker: directed and randomized toggles against a queue-based
// reference model; a second instance with a 4-bit counter exercises saturation.
module tb_cdc_pattern_checker;
    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [1:0] mode;
    logic [7:0] cap_data;
    logic       cap_edge;
    logic       rd_en;

    logic [15:0] num_edges_a, num_mis_a;
    logic [15:0] first_a;
    logic        pass_a;
    logic [3:0]  num_edges_b, num_mis_b;
    logic [15:0] first_b;
    logic        pass_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cdc_pattern_checker_if #(.DATA_W(8), .CNT_W(16), .LOG_DEPTH(4)) bus_a ();
    cdc_pattern_checker_if #(.DATA_W(8), .CNT_W(4),  .LOG_DEPTH(4)) bus_b ();

    assign bus_a.capture_data = cap_data;
    assign bus_a.capture_edge = cap_edge;
    assign bus_a.log_rd_en    = rd_en;
    assign bus_b.capture_data = cap_data;
    assign bus_b.capture_edge = cap_edge;
    assign bus_b.log_rd_en    = rd_en;

    cdc_pattern_checker #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(16), .LOG_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .mode(mode), .bus(bus_a.slave),
        .num_edges(num_edges_a), .num_miscompares(num_mis_a),
        .first_miscompare(first_a), .pass(pass_a)
    );

    cdc_pattern_checker #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(4), .LOG_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .mode(mode), .bus(bus_b.slave),
        .num_edges(num_edges_b), .num_miscompares(num_mis_b),
        .first_miscompare(first_b), .pass(pass_b)
    );

    // Reference model: edge k since reset/clear expects pattern(mode, k).
    logic [1:0]  m_mode;
    int          m_k, m_edges, m_mis;
    logic [15:0] m_first;
    logic        m_ovf;
    logic [31:0] m_log [$];

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [7:0] model_pattern(input logic [1:0] m, input int k);
        int j;
        case (m)
            2'b01:   return 8'(k % 256);
            2'b10:   return 8'(1 << (k % 8));
            default: begin
                j = k % 4;
                return 8'((1 << j) | (1 << (7 - j)));
            end
        endcase
    endfunction

    task automatic model_reset(input logic [1:0] m);
        m_mode = m; m_k = 0; m_edges = 0; m_mis = 0; m_first = '0; m_ovf = 1'b0;
        m_log.delete();
    endtask

    task automatic model_edge(input logic [7:0] d);
        logic [7:0] e;
        e = model_pattern(m_mode, m_k);
        m_k++;
        m_edges++;
        if (d != e) begin
            m_mis++;
            if (m_mis == 1) m_first = {e, d};
            if (m_log.size() < 4) m_log.push_back({16'(sat(m_edges, 16)), e, d});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".edges"},  num_edges_a, 64'(sat(m_edges, 16)));
        chk({tag, ".mis"},    num_mis_a,   64'(sat(m_mis, 16)));
        chk({tag, ".first"},  first_a,     m_first);
        chk({tag, ".pass"},   pass_a,      (m_edges != 0 && m_mis == 0));
        chk({tag, ".lvalid"}, bus_a.log_valid, (m_log.size() != 0));
        chk({tag, ".lcount"}, bus_a.log_count, 64'(m_log.size()));
        chk({tag, ".lovf"},   bus_a.log_overflow, m_ovf);
        chk({tag, ".ldata"},  bus_a.log_data, (m_log.size() != 0) ? 64'(m_log[0]) : 64'd0);
        chk({tag, ".edges_b"}, num_edges_b, 64'(sat(m_edges, 4)));
        chk({tag, ".mis_b"},   num_mis_b,   64'(sat(m_mis, 4)));
    endtask

    task automatic toggle(input logic [7:0] d, input int gap);
        @(posedge clk); #1;
        cap_data = d;
        cap_edge = ~cap_edge;
        model_edge(d);
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        if (m_log.size() != 0) void'(m_log.pop_front());
    endtask

    task automatic do_clear(input logic [1:0] m);
        @(posedge clk); #1;
        clear = 1'b1;
        mode  = m;
        @(posedge clk); #1 clear = 1'b0;
        model_reset(m);
    endtask

    logic [7:0] t1_vals [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h81, 8'h42, 8'h24, 8'h18};
    logic [7:0] t2_vals [5] = '{8'h81, 8'h42, 8'h24, 8'h19, 8'h81};

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        reset = 1'b0; clear = 1'b0; mode = 2'b00;
        cap_data = '0; cap_edge = 1'b0; rd_en = 1'b0;
        model_reset(2'b00);
        repeat (3) @(posedge clk);
        #1 check_all("reset");
        reset = 1'b1;
        repeat (10) @(posedge clk);

        // Mirrored pattern, all correct; first edge lands SYNC_STAGES+2 clocks after the toggle.
        @(posedge clk); #1;
        cap_data = t1_vals[0];
        cap_edge = ~cap_edge;
        model_edge(t1_vals[0]);
        repeat (3) @(posedge clk);
        #1 chk("t1.lat_before", num_edges_a, 0);
        @(posedge clk);
        #1 chk("t1.lat_after", num_edges_a, 1);
        repeat (3) @(posedge clk);
        for (int i = 1; i < 8; i++) toggle(t1_vals[i], 8);
        settle();
        check_all("t1");
        chk("t1.edges_c", num_edges_a, 8);
        chk("t1.pass_c", pass_a, 1);

        // Single miscompare on the 4th edge.
        do_clear(2'b00);
        for (int i = 0; i < 5; i++) toggle(t2_vals[i], 6);
        settle();
        check_all("t2");
        chk("t2.ldata_c", bus_a.log_data, {16'd4, 8'h18, 8'h19});
        chk("t2.first_c", first_a, 16'h1819);
        chk("t2.mis_c", num_mis_a, 1);

        // Log overflow: six miscompares, nothing read.
        do_clear(2'b00);
        for (int i = 0; i < 6; i++) begin
            d = model_pattern(m_mode, m_k) ^ 8'($urandom_range(1, 255));
            toggle(d, 5);
        end
        settle();
        check_all("t3");
        chk("t3.count_c", bus_a.log_count, 4);
        chk("t3.ovf_c", bus_a.log_overflow, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t3.idx", bus_a.log_data[31:16], 64'(i + 1));
            pop_one();
            check_all("t3.pop");
        end
        chk("t3.ovf_sticky", bus_a.log_overflow, 1);
        pop_one();
        check_all("t3.empty_pop");

        // Increment mode through a full wrap, then walking one.
        do_clear(2'b01);
        for (int i = 0; i < 257; i++) toggle(8'(i % 256), 5);
        settle();
        check_all("t4.inc");
        chk("t4.inc_edges_c", num_edges_a, 257);
        do_clear(2'b10);
        for (int i = 0; i < 9; i++) toggle(8'(1 << (i % 8)), 5);
        settle();
        check_all("t4.walk");

        // Randomized rounds: random mode, mixed good/bad data, random pops.
        for (int r = 0; r < 6; r++) begin
            do_clear(2'($urandom_range(0, 3)));
            for (int i = 0; i < int'($urandom_range(8, 20)); i++) begin
                d = model_pattern(m_mode, m_k);
                if ($urandom_range(0, 2) == 0) d = 8'($urandom);
                toggle(d, int'($urandom_range(5, 7)));
            end
            settle();
            check_all("rnd");
            for (int p = 0; p < int'($urandom_range(0, 3)); p++) begin
                pop_one();
                check_all("rnd.pop");
            end
        end

        // capture_edge high across reset release, then a clear while static.
        @(posedge clk); #1;
        reset = 1'b0;
        cap_edge = 1'b1;
        mode = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        model_reset(2'b00);
        repeat (20) @(posedge clk);
        #1 check_all("t5.release");
        chk("t5.edges_c", num_edges_a, 0);
        do_clear(2'b00);
        repeat (10) @(posedge clk);
        #1 check_all("t5.clear");

        // Saturation on the 4-bit instance, then clear into walking-one mode.
        for (int i = 0; i < 20; i++) toggle(model_pattern(m_mode, m_k), 5);
        settle();
        check_all("t6.sat");
        chk("t6.sat_c", num_edges_b, 15);
        do_clear(2'b10);
        #1 check_all("t6.clear");
        toggle(8'h01, 5);
        settle();
        check_all("t6.first01");
        chk("t6.mis0_c", num_mis_a, 0);

        // Fill the log, then push and pop in the same cycle while full.
        for (int i = 0; i < 4; i++) toggle(~model_pattern(m_mode, m_k), 5);
        settle();
        check_all("t6.full");
        d = model_pattern(m_mode, m_k) ^ 8'hF0;
        @(posedge clk); #1;
        cap_data = d;
        cap_edge = ~cap_edge;
        repeat (3) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        if (m_log.size() != 0) void'(m_log.pop_front());
        model_edge(d);
        settle();
        check_all("t6.pushpop_full");
        chk("t6.count_c", bus_a.log_count, 4);
        chk("t6.ovf_c", bus_a.log_overflow, 0);

        // Drain, then push and pop together while empty.
        for (int i = 0; i < 4; i++) pop_one();
        #1 check_all("t6.drained");
        d = model_pattern(m_mode, m_k) ^ 8'h0F;
        @(posedge clk); #1;
        cap_data = d;
        cap_edge = ~cap_edge;
        repeat (3) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        if (m_log.size() != 0) void'(m_log.pop_front());
        model_edge(d);
        settle();
        check_all("t6.pushpop_empty");
        chk("t6.count1_c", bus_a.log_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
